fixed_mac_pe: RTL and testbench

Parametrised, pipelined multi-lane fixed-bit MAC processing element, the next generation of the 8-bit systolic PE. Each valid beat multiplies LANES operand/weight pairs with per-operand signedness, sums them, and adds the incoming column partial sum. An output-stationary mode accumulates a programmable number of beats locally before forwarding. It sits in the fixed-bit PE array, one instance per array cell; psum_fwd chains to the next row's psum_in.

---
 rtl/fixed_mac_pe_if.sv | 30 +++
 rtl/fixed_mac_pe.sv | 209 ++++++++++++++++++++
 tb/tb_fixed_mac_pe.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fixed_mac_pe_if.sv
// Beat and result bundle for one fixed_mac_pe array cell.
// The master drives beats into the PE; the slave side is the PE itself.
interface fixed_mac_pe_if #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned LANES     = 4,
   parameter int unsigned PSUM_W    = 32,
   parameter int unsigned ACC_LEN_W = 8
);
   logic                    in_valid;
   logic [LANES*DATA_W-1:0] in;
   logic [LANES*DATA_W-1:0] weight;
   logic                    s_in;
   logic                    s_weight;
   logic [PSUM_W-1:0]       psum_in;
   logic                    mode;
   logic [ACC_LEN_W-1:0]    acc_len;
   logic                    out_valid;
   logic [PSUM_W-1:0]       psum_fwd;
   logic                    busy;

   modport master (
      output in_valid, in, weight, s_in, s_weight, psum_in, mode, acc_len,
      input  out_valid, psum_fwd, busy
   );

   modport slave (
      input  in_valid, in, weight, s_in, s_weight, psum_in, mode, acc_len,
      output out_valid, psum_fwd, busy
   );
endinterface

// File: rtl/fixed_mac_pe.sv
// Pipelined multi-lane fixed-bit MAC PE with forward and output-stationary accumulate modes.
// Define FIXED_MAC_SAT_EN to saturate every S2 addition instead of wrapping.
module fixed_mac_pe #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned LANES     = 4,
   parameter int unsigned PSUM_W    = 32,
   parameter int unsigned ACC_LEN_W = 8
) (
   input logic           clk,
   input logic           rst,
   fixed_mac_pe_if.slave bus
);
   localparam int unsigned OP_W   = DATA_W + 1;
   localparam int unsigned PROD_W = 2 * DATA_W + 2;
   localparam int unsigned SUM_W  = PROD_W + $clog2(LANES) + 1;
   localparam int unsigned EXT_W  = (SUM_W > PSUM_W) ? SUM_W : PSUM_W;

   typedef enum logic {StIdle, StAcc} state_e;

   function automatic logic [PSUM_W-1:0] psum_add(input logic [PSUM_W-1:0] a,
                                                  input logic [PSUM_W-1:0] b);
      logic [PSUM_W:0] s;
      s = {a[PSUM_W-1], a} + {b[PSUM_W-1], b};
`ifdef FIXED_MAC_SAT_EN
      if (s[PSUM_W] != s[PSUM_W-1]) begin
         psum_add = s[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
      end else begin
         psum_add = s[PSUM_W-1:0];
      end
`else
      psum_add = s[PSUM_W-1:0];
`endif
   endfunction

   // Lane multipliers: each operand widened by one bit so signed and unsigned share one path
   logic signed [PROD_W-1:0] w_prod [LANES];

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [DATA_W-1:0]      w_a_raw;
      logic [DATA_W-1:0]      w_b_raw;
      logic signed [OP_W-1:0] w_a;
      logic signed [OP_W-1:0] w_b;

      assign w_a_raw   = bus.in[k*DATA_W +: DATA_W];
      assign w_b_raw   = bus.weight[k*DATA_W +: DATA_W];
      assign w_a       = {bus.s_in & w_a_raw[DATA_W-1], w_a_raw};
      assign w_b       = {bus.s_weight & w_b_raw[DATA_W-1], w_b_raw};
      assign w_prod[k] = w_a * w_b;
   end

   logic [ACC_LEN_W-1:0] w_len_eff;
   assign w_len_eff = (bus.acc_len == '0) ? ACC_LEN_W'(1) : bus.acc_len;

   // Stage 1
   logic                     r_s1_valid;
   logic signed [PROD_W-1:0] r_s1_prod [LANES];
   logic [PSUM_W-1:0]        r_s1_psum;
   logic                     r_s1_mode;
   logic [ACC_LEN_W-1:0]     r_s1_len;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_valid <= bus.in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (bus.in_valid) begin
         r_s1_prod <= w_prod;
         r_s1_psum <= bus.psum_in;
         r_s1_mode <= bus.mode;
         r_s1_len  <= w_len_eff;
      end
   end

   logic signed [EXT_W-1:0] w_sum_ext;
   logic [PSUM_W-1:0]       w_s1_sum;

   always_comb begin
      w_sum_ext = '0;
      for (int k = 0; k < LANES; k++) begin
         w_sum_ext = w_sum_ext + EXT_W'(r_s1_prod[k]);
      end
   end

   assign w_s1_sum = w_sum_ext[PSUM_W-1:0];

   // Group FSM: classifies each S1 beat as bias-load / accumulate / emit for S2
   state_e               r_state;
   state_e               w_state_d;
   logic [ACC_LEN_W-1:0] r_cnt;
   logic [ACC_LEN_W-1:0] w_cnt_d;
   logic [ACC_LEN_W-1:0] w_cnt_inc;
   logic [ACC_LEN_W-1:0] r_len;
   logic [ACC_LEN_W-1:0] w_len_d;
   logic                 w_load;
   logic                 w_upd;
   logic                 w_emit;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_len   <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_len   <= w_len_d;
      end
   end

   assign w_cnt_inc = r_cnt + ACC_LEN_W'(1);

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_len_d   = r_len;
      w_load    = 1'b0;
      w_upd     = 1'b0;
      w_emit    = 1'b0;
      if (r_s1_valid) begin
         case (r_state)
            StIdle: begin
               w_load = 1'b1;
               if (!r_s1_mode) begin
                  w_emit = 1'b1;
               end else begin
                  w_upd = 1'b1;
                  if (r_s1_len == ACC_LEN_W'(1)) begin
                     w_emit = 1'b1;
                  end else begin
                     w_state_d = StAcc;
                     w_cnt_d   = ACC_LEN_W'(1);
                     w_len_d   = r_s1_len;
                  end
               end
            end
            StAcc: begin
               w_upd   = 1'b1;
               w_cnt_d = w_cnt_inc;
               if (w_cnt_inc == r_len) begin
                  w_emit    = 1'b1;
                  w_state_d = StIdle;
                  w_cnt_d   = '0;
               end
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

   // Stage 2
   logic [PSUM_W-1:0] r_s2_sum;
   logic [PSUM_W-1:0] r_s2_psum;
   logic              r_s2_load;
   logic              r_s2_upd;
   logic              r_s2_emit;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_load <= 1'b0;
         r_s2_upd  <= 1'b0;
         r_s2_emit <= 1'b0;
      end else begin
         r_s2_load <= w_load;
         r_s2_upd  <= w_upd;
         r_s2_emit <= w_emit;
      end
   end

   always_ff @(posedge clk) begin
      if (r_s1_valid) begin
         r_s2_sum  <= w_s1_sum;
         r_s2_psum <= r_s1_psum;
      end
   end

   logic [PSUM_W-1:0] r_acc;
   logic [PSUM_W-1:0] r_psum_fwd;
   logic              r_out_valid;
   logic [PSUM_W-1:0] w_base;
   logic [PSUM_W-1:0] w_res;

   // psum_in seeds the result only on forward beats and group openers
   assign w_base = r_s2_load ? r_s2_psum : r_acc;
   assign w_res  = psum_add(w_base, r_s2_sum);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc       <= '0;
         r_psum_fwd  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= r_s2_emit;
         if (r_s2_upd) begin
            r_acc <= w_res;
         end
         if (r_s2_emit) begin
            r_psum_fwd <= w_res;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.psum_fwd  = r_psum_fwd;
   assign bus.busy      = (r_state == StAcc);
endmodule

// File: tb/tb_fixed_mac_pe.sv
// Self-checking bench for fixed_mac_pe: directed cases plus random beats vs. a group-level model.
// Honours FIXED_MAC_SAT_EN for the saturation expectations.
module tb_fixed_mac_pe;
   logic clk;
   logic rst;

   fixed_mac_pe_if #(.PSUM_W(32)) bus ();
   fixed_mac_pe_if #(.PSUM_W(16)) bus16 ();

   fixed_mac_pe #(.PSUM_W(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   fixed_mac_pe #(.PSUM_W(16)) u_dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          n      = 0;
   logic [31:0] exp_p [int];
   logic [31:0] last_psum = '0;

   bit          g_open = 1'b0;
   int          g_cnt  = 0;
   int          g_len  = 0;
   logic [31:0] g_acc  = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] lane_sum(input logic [31:0] a, input logic [31:0] w,
                                            input bit sa, input bit sw);
      int         s;
      int         av;
      int         wv;
      logic [7:0] ab;
      logic [7:0] wb;
      s = 0;
      for (int k = 0; k < 4; k++) begin
         ab = a[k*8 +: 8];
         wb = w[k*8 +: 8];
         av = sa ? int'($signed(ab)) : int'(ab);
         wv = sw ? int'($signed(wb)) : int'(wb);
         s  = s + av * wv;
      end
      return s;
   endfunction

   function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b);
      longint s;
      s = longint'($signed(a)) + longint'($signed(b));
`ifdef FIXED_MAC_SAT_EN
      if (s > longint'(32'sh7FFF_FFFF)) s = longint'(32'sh7FFF_FFFF);
      if (s < longint'(32'sh8000_0000)) s = longint'(32'sh8000_0000);
`endif
      return s[31:0];
   endfunction

   // One clock: drive a beat, update the model, then check what the DUT shows after the edge
   task automatic step(input bit v, input logic [31:0] a, input logic [31:0] w,
                       input bit sa, input bit sw, input logic [31:0] p,
                       input bit m, input logic [7:0] len);
      bit          prev_open;
      logic [31:0] ls;
      int          l_eff;
      bus.in_valid = v;
      bus.in       = a;
      bus.weight   = w;
      bus.s_in     = sa;
      bus.s_weight = sw;
      bus.psum_in  = p;
      bus.mode     = m;
      bus.acc_len  = len;
      prev_open    = g_open;
      n++;
      if (v) begin
         ls = lane_sum(a, w, sa, sw);
         if (!g_open) begin
            if (!m) begin
               exp_p[n+2] = add32(ls, p);
            end else begin
               l_eff = (len == 0) ? 1 : int'(len);
               g_acc = add32(ls, p);
               if (l_eff == 1) begin
                  exp_p[n+2] = g_acc;
               end else begin
                  g_open = 1'b1;
                  g_cnt  = 1;
                  g_len  = l_eff;
               end
            end
         end else begin
            g_acc = add32(g_acc, ls);
            g_cnt++;
            if (g_cnt == g_len) begin
               exp_p[n+2] = g_acc;
               g_open     = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      if (exp_p.exists(n)) begin
         chk("out_valid pulse", {31'd0, bus.out_valid}, 32'd1);
         chk("psum_fwd result", bus.psum_fwd, exp_p[n]);
         last_psum = exp_p[n];
         exp_p.delete(n);
      end else begin
         chk("out_valid quiet", {31'd0, bus.out_valid}, 32'd0);
         chk("psum_fwd hold", bus.psum_fwd, last_psum);
      end
      chk("busy", {31'd0, bus.busy}, {31'd0, prev_open});
   endtask

   task automatic idle();
      step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 8'd0);
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      bus.in_valid   = 1'b0;
      bus16.in_valid = 1'b0;
      n++;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      g_open    = 1'b0;
      g_cnt     = 0;
      g_acc     = '0;
      last_psum = '0;
      exp_p.delete();
      chk("reset psum_fwd", bus.psum_fwd, 32'd0);
      chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset busy", {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      logic [15:0] exp16;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in = '0; bus.weight = '0; bus.s_in = 1'b0;
      bus.s_weight = 1'b0; bus.psum_in = '0; bus.mode = 1'b0; bus.acc_len = '0;
      bus16.in_valid = 1'b0; bus16.in = '0; bus16.weight = '0; bus16.s_in = 1'b0;
      bus16.s_weight = 1'b0; bus16.psum_in = '0; bus16.mode = 1'b0; bus16.acc_len = '0;
      do_reset();

      // Forward beats with each signedness combination
      step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd10, 1'b0, 8'd0);
      idle(); idle();
      chk("fwd signed", bus.psum_fwd, 32'd14);
      step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0);
      idle(); idle();
      chk("fwd unsigned", bus.psum_fwd, 32'd260100);
      step(1'b1, 32'h8080_8080, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0, 1'b0, 8'd0);
      idle(); idle();
      chk("fwd mixed", bus.psum_fwd, 32'hFFFE_0200);

      // Accumulate group of 3, then a back-to-back group of 2
      step(1'b1, 32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0, 32'd5, 1'b1, 8'd3);
      step(1'b1, 32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0, 32'd99, 1'b0, 8'd7);
      step(1'b1, 32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0, 32'd77, 1'b1, 8'd1);
      step(1'b1, 32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0, 32'd0, 1'b1, 8'd2);
      step(1'b1, 32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0, 32'd0, 1'b1, 8'd2);
      chk("acc group", bus.psum_fwd, 32'd29);
      idle(); idle();
      chk("acc back-to-back", bus.psum_fwd, 32'd8);

      // 16-bit overflow on the narrow instance
      bus16.in_valid = 1'b1;
      bus16.in       = 32'h0000_0001;
      bus16.weight   = 32'h0000_0001;
      bus16.psum_in  = 16'h7FFF;
      idle();
      bus16.in_valid = 1'b0;
      idle(); idle();
`ifdef FIXED_MAC_SAT_EN
      exp16 = 16'h7FFF;
`else
      exp16 = 16'h8000;
`endif
      chk("ovf16 out_valid", {31'd0, bus16.out_valid}, 32'd1);
      chk("ovf16 psum", {16'd0, bus16.psum_fwd}, {16'd0, exp16});

      // Reset in the middle of an acc_len=4 group
      step(1'b1, 32'h0303_0303, 32'h0404_0404, 1'b0, 1'b0, 32'd1, 1'b1, 8'd4);
      step(1'b1, 32'h0303_0303, 32'h0404_0404, 1'b0, 1'b0, 32'd1, 1'b1, 8'd4);
      do_reset();
      idle(); idle(); idle();
      step(1'b1, 32'h0102_0304, 32'h0202_0202, 1'b0, 1'b0, 32'd100, 1'b0, 8'd0);
      idle(); idle();
      chk("post-reset fwd", bus.psum_fwd, 32'd120);

      // Random beats: mixed modes, lengths (including 0), signedness and validity
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 8), $urandom, $urandom, 1'($urandom), 1'($urandom),
              $urandom, 1'($urandom), 8'($urandom_range(0, 4)));
      end
      for (int i = 0; i < 8; i++) idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
